// File: rtl/udp_reg_tx_if.sv
// udp_reg_tx_if: 8-bit AXI-stream byte bus from udp_reg_tx to the UDP stack.
//
// Handshake: a byte moves on a rising clk edge where tvalid && tready are
// both high. The master holds tdata/tlast stable while tvalid && !tready,
// and once tvalid is raised it stays high until the tlast byte has moved.
// tready may change freely and never depends on tvalid. tuser is unused (0).
interface udp_reg_tx_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/udp_reg_tx.sv
// udp_reg_tx: on start, snapshots rd_val and streams one UDP payload frame:
// MAGIC (2 bytes), seq (2 bytes), then Nregs registers of 4 bytes each,
// all big-endian. One extra start may be queued while a frame is in flight.
// Optional feature macro UDP_REG_TX_CSUM_EN appends a 16-bit byte-sum
// checksum (2 bytes) and moves tlast onto its second byte.
// All stream outputs are registered; tready only gates the advance enable.
module udp_reg_tx #(
    parameter int          Nregs = 16,
    parameter logic [15:0] MAGIC = 16'hA55A
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [Nregs-1:0][31:0] rd_val,
    output logic                  busy,
    output logic                  pending,
    output logic [15:0]           seq,
    output logic [1:0]            dbg_state,
    udp_reg_tx_if.master          m
);

    localparam int RW = (Nregs > 1) ? $clog2(Nregs) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t                   state_q, state_n;
    logic [1:0]               byte_q, byte_n;
    logic [RW-1:0]            reg_q, reg_n;
    logic                     tvalid_q, tvalid_n;
    logic [7:0]               tdata_q, tdata_n;
    logic                     tlast_q, tlast_n;
    logic                     busy_q, busy_n;
    logic                     pending_q, pending_n;
    logic [15:0]              seq_q, seq_n;
    logic [15:0]              seq_hdr_q;
    logic [Nregs-1:0][31:0]   snap_q;
    logic                     load;
    logic                     adv;
    logic                     last_data;
    logic [31:0]              word;
`ifdef UDP_REG_TX_CSUM_EN
    logic [15:0]              csum_q, csum_n;
    logic [15:0]              csum_sum;
`endif

    assign adv       = tvalid_q && m.tready;
    assign last_data = (reg_q == RW'(Nregs - 1)) && (byte_q == 2'd3);

    assign m.tvalid  = tvalid_q;
    assign m.tdata   = tdata_q;
    assign m.tlast   = tlast_q;
    assign m.tuser   = 1'b0;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign seq       = seq_q;
    assign dbg_state = state_q;

    // Next-state logic: counters point at the byte currently presented, and
    // the byte to present next is computed here so the output stays registered.
    always_comb begin
        state_n   = state_q;
        byte_n    = byte_q;
        reg_n     = reg_q;
        tvalid_n  = tvalid_q;
        tdata_n   = tdata_q;
        tlast_n   = tlast_q;
        busy_n    = busy_q;
        pending_n = pending_q;
        seq_n     = seq_q;
        load      = 1'b0;
        word      = '0;
`ifdef UDP_REG_TX_CSUM_EN
        csum_n    = csum_q;
        csum_sum  = csum_q + {8'd0, tdata_q};
`endif
        case (state_q)
            IDLE: begin
                if (start || pending_q) begin
                    state_n   = HDR;
                    byte_n    = 2'd0;
                    reg_n     = '0;
                    tvalid_n  = 1'b1;
                    tdata_n   = MAGIC[15:8];
                    tlast_n   = 1'b0;
                    busy_n    = 1'b1;
                    pending_n = 1'b0;
                    load      = 1'b1;
`ifdef UDP_REG_TX_CSUM_EN
                    csum_n    = '0;
`endif
                end
            end
            HDR: begin
                if (adv) begin
`ifdef UDP_REG_TX_CSUM_EN
                    csum_n = csum_sum;
`endif
                    if (byte_q == 2'd3) begin
                        state_n = DATA;
                        byte_n  = 2'd0;
                        reg_n   = '0;
                        tdata_n = snap_q[0][31:24];
                    end else begin
                        byte_n = byte_q + 2'd1;
                        case (byte_n)
                            2'd1:    tdata_n = MAGIC[7:0];
                            2'd2:    tdata_n = seq_hdr_q[15:8];
                            default: tdata_n = seq_hdr_q[7:0];
                        endcase
                    end
                end
            end
            DATA: begin
                if (adv) begin
`ifdef UDP_REG_TX_CSUM_EN
                    csum_n = csum_sum;
`endif
                    if (last_data) begin
`ifdef UDP_REG_TX_CSUM_EN
                        state_n = CSUM;
                        byte_n  = 2'd0;
                        tdata_n = csum_sum[15:8];
                        tlast_n = 1'b0;
`else
                        state_n  = IDLE;
                        tvalid_n = 1'b0;
                        tdata_n  = 8'd0;
                        tlast_n  = 1'b0;
                        busy_n   = 1'b0;
                        seq_n    = seq_q + 16'd1;
`endif
                    end else begin
                        if (byte_q == 2'd3) begin
                            reg_n  = reg_q + RW'(1);
                            byte_n = 2'd0;
                        end else begin
                            byte_n = byte_q + 2'd1;
                        end
                        word    = snap_q[reg_n];
                        tdata_n = 8'(word >> {~byte_n, 3'b000});
`ifdef UDP_REG_TX_CSUM_EN
                        tlast_n = 1'b0;
`else
                        tlast_n = (reg_n == RW'(Nregs - 1)) && (byte_n == 2'd3);
`endif
                    end
                end
            end
            CSUM: begin
`ifdef UDP_REG_TX_CSUM_EN
                if (adv) begin
                    if (byte_q == 2'd0) begin
                        byte_n  = 2'd1;
                        tdata_n = csum_q[7:0];
                        tlast_n = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        tvalid_n = 1'b0;
                        tdata_n  = 8'd0;
                        tlast_n  = 1'b0;
                        busy_n   = 1'b0;
                        seq_n    = seq_q + 16'd1;
                    end
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        // A start that arrives while a frame is in flight is queued once.
        if ((state_q != IDLE) && start) begin
            pending_n = 1'b1;
        end
    end

    // State, counters and registered stream outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            byte_q    <= 2'd0;
            reg_q     <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= 8'd0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            seq_q     <= 16'd0;
        end else begin
            state_q   <= state_n;
            byte_q    <= byte_n;
            reg_q     <= reg_n;
            tvalid_q  <= tvalid_n;
            tdata_q   <= tdata_n;
            tlast_q   <= tlast_n;
            busy_q    <= busy_n;
            pending_q <= pending_n;
            seq_q     <= seq_n;
        end
    end

    // Register-file snapshot and header sequence number, frozen at frame start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_q    <= '0;
            seq_hdr_q <= 16'd0;
        end else if (load) begin
            snap_q    <= rd_val;
            seq_hdr_q <= seq_q;
        end
    end

`ifdef UDP_REG_TX_CSUM_EN
    // Running byte sum of the header and register bytes sent so far.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csum_q <= 16'd0;
        end else begin
            csum_q <= csum_n;
        end
    end
`endif

endmodule
